// File: rtl/video_layer_mixer_if.sv
// Pixel, timing and configuration bundle between a video source and the layer mixer.
// The master side drives layers, strobes and config writes; the slave side returns the composite.
interface video_layer_mixer_if #(
   parameter int NLAYERS  = 4,
   parameter int COLSPC   = 10,
   parameter int ALPHASPC = 4
);
   localparam int SELW = $clog2(NLAYERS);

   logic                             video_enable;
   logic                             vsync;
   logic                             hsync;
   logic                             frame_start;
   logic                             line_start;
   logic [NLAYERS-1:0][COLSPC-1:0]   layer_red;
   logic [NLAYERS-1:0][COLSPC-1:0]   layer_green;
   logic [NLAYERS-1:0][COLSPC-1:0]   layer_blue;

   logic                             cfg_wr;
   logic [SELW-1:0]                  cfg_sel;
   logic                             cfg_en;
   logic [3*COLSPC-1:0]              cfg_key;
   logic [ALPHASPC-1:0]              cfg_alpha;
   logic                             cfg_pending;

   logic [COLSPC-1:0]                red;
   logic [COLSPC-1:0]                green;
   logic [COLSPC-1:0]                blue;
   logic                             de_out;
   logic                             vsync_out;
   logic                             hsync_out;
   logic                             frame_start_out;
   logic                             line_start_out;

   modport master (
      output video_enable, vsync, hsync, frame_start, line_start,
      output layer_red, layer_green, layer_blue,
      output cfg_wr, cfg_sel, cfg_en, cfg_key, cfg_alpha,
      input  cfg_pending,
      input  red, green, blue,
      input  de_out, vsync_out, hsync_out, frame_start_out, line_start_out
   );

   modport slave (
      input  video_enable, vsync, hsync, frame_start, line_start,
      input  layer_red, layer_green, layer_blue,
      input  cfg_wr, cfg_sel, cfg_en, cfg_key, cfg_alpha,
      output cfg_pending,
      output red, green, blue,
      output de_out, vsync_out, hsync_out, frame_start_out, line_start_out
   );
endinterface

// File: rtl/video_layer_mixer.sv
// N-layer compositor: colour-key/enable visibility, top-two alpha blend, 3-cycle pipeline.
// Layer configuration is double-buffered and swapped in on frame_start.
module video_layer_mixer #(
   parameter int NLAYERS  = 4,
   parameter int COLSPC   = 10,
   parameter int ALPHASPC = 4
) (
   input  logic                 video_clk_pix,
   input  logic                 video_rst_n,
   video_layer_mixer_if.slave   bus
);
   localparam int PW = COLSPC + ALPHASPC + 1;

   typedef struct packed {
      logic                en;
      logic [3*COLSPC-1:0] key;
      logic [ALPHASPC-1:0] alpha;
   } layer_cfg_t;

   // Default set reproduces plain priority compositing with black as transparent.
   localparam layer_cfg_t CFG_DEFAULT = '{1'b1, {(3*COLSPC){1'b0}}, {ALPHASPC{1'b1}}};

   layer_cfg_t pend_cfg [NLAYERS];
   layer_cfg_t act_cfg  [NLAYERS];
   logic       pending;
   logic       wr_ok;

   assign wr_ok           = bus.cfg_wr && (int'(bus.cfg_sel) < NLAYERS);
   assign bus.cfg_pending = pending;

   always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
      if (!video_rst_n) begin
         for (int i = 0; i < NLAYERS; i++) begin
            pend_cfg[i] <= CFG_DEFAULT;
            act_cfg[i]  <= CFG_DEFAULT;
         end
         pending <= 1'b0;
      end else begin
         if (bus.frame_start) begin
            for (int i = 0; i < NLAYERS; i++) act_cfg[i] <= pend_cfg[i];
            pending <= 1'b0;
         end
         // A write landing on frame_start goes to pending only and keeps the flag up.
         if (wr_ok) begin
            pend_cfg[bus.cfg_sel] <= '{bus.cfg_en, bus.cfg_key, bus.cfg_alpha};
            pending               <= 1'b1;
         end
      end
   end

   logic [NLAYERS-1:0]               vis_in;
   logic [NLAYERS-1:0][ALPHASPC-1:0] alpha_in;
   logic [4:0]                       strb_in;

   assign strb_in = {bus.video_enable, bus.vsync, bus.hsync, bus.frame_start, bus.line_start};

   always_comb begin
      vis_in   = '0;
      alpha_in = '0;
      for (int i = 0; i < NLAYERS; i++) begin
         vis_in[i]   = act_cfg[i].en &&
                       ({bus.layer_red[i], bus.layer_green[i], bus.layer_blue[i]} != act_cfg[i].key);
         alpha_in[i] = act_cfg[i].alpha;
      end
   end

   logic [NLAYERS-1:0][COLSPC-1:0]   s1_r, s1_g, s1_b;
   logic [NLAYERS-1:0]               s1_vis;
   logic [NLAYERS-1:0][ALPHASPC-1:0] s1_alpha;
   logic [4:0]                       s1_strb;

   always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
      if (!video_rst_n) begin
         s1_r     <= '0;
         s1_g     <= '0;
         s1_b     <= '0;
         s1_vis   <= '0;
         s1_alpha <= '0;
         s1_strb  <= '0;
      end else begin
         s1_r     <= bus.layer_red;
         s1_g     <= bus.layer_green;
         s1_b     <= bus.layer_blue;
         s1_vis   <= vis_in;
         s1_alpha <= alpha_in;
         s1_strb  <= strb_in;
      end
   end

   logic [COLSPC-1:0]   top_r, top_g, top_b;
   logic [COLSPC-1:0]   bot_r, bot_g, bot_b;
   logic [ALPHASPC-1:0] top_alpha;

   // Ascending scan: each newly visible layer pushes the previous top down to bottom.
   always_comb begin
      top_r     = '0;
      top_g     = '0;
      top_b     = '0;
      bot_r     = '0;
      bot_g     = '0;
      bot_b     = '0;
      top_alpha = '1;
      for (int i = 0; i < NLAYERS; i++) begin
         if (s1_vis[i]) begin
            bot_r     = top_r;
            bot_g     = top_g;
            bot_b     = top_b;
            top_r     = s1_r[i];
            top_g     = s1_g[i];
            top_b     = s1_b[i];
            top_alpha = s1_alpha[i];
         end
      end
   end

   logic [COLSPC-1:0]   s2_top_r, s2_top_g, s2_top_b;
   logic [COLSPC-1:0]   s2_bot_r, s2_bot_g, s2_bot_b;
   logic [ALPHASPC-1:0] s2_alpha;
   logic [4:0]          s2_strb;

   always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
      if (!video_rst_n) begin
         s2_top_r <= '0;
         s2_top_g <= '0;
         s2_top_b <= '0;
         s2_bot_r <= '0;
         s2_bot_g <= '0;
         s2_bot_b <= '0;
         s2_alpha <= '0;
         s2_strb  <= '0;
      end else begin
         s2_top_r <= top_r;
         s2_top_g <= top_g;
         s2_top_b <= top_b;
         s2_bot_r <= bot_r;
         s2_bot_g <= bot_g;
         s2_bot_b <= bot_b;
         s2_alpha <= top_alpha;
         s2_strb  <= s1_strb;
      end
   end

   function automatic logic [COLSPC-1:0] blend(input logic [COLSPC-1:0]   t,
                                               input logic [COLSPC-1:0]   b,
                                               input logic [ALPHASPC-1:0] a);
      logic [PW-1:0] inv;
      logic [PW-1:0] sum;
      inv = (PW'(1) << ALPHASPC) - PW'(a);
      sum = PW'(t) * PW'(a) + PW'(b) * inv;
      if (a == {ALPHASPC{1'b1}}) return t;
      return COLSPC'(sum >> ALPHASPC);
   endfunction

   logic [COLSPC-1:0] mix_r, mix_g, mix_b;

   assign mix_r = blend(s2_top_r, s2_bot_r, s2_alpha);
   assign mix_g = blend(s2_top_g, s2_bot_g, s2_alpha);
   assign mix_b = blend(s2_top_b, s2_bot_b, s2_alpha);

   always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
      if (!video_rst_n) begin
         bus.red             <= '0;
         bus.green           <= '0;
         bus.blue            <= '0;
         bus.de_out          <= 1'b0;
         bus.vsync_out       <= 1'b0;
         bus.hsync_out       <= 1'b0;
         bus.frame_start_out <= 1'b0;
         bus.line_start_out  <= 1'b0;
      end else begin
         bus.red             <= s2_strb[4] ? mix_r : '0;
         bus.green           <= s2_strb[4] ? mix_g : '0;
         bus.blue            <= s2_strb[4] ? mix_b : '0;
         bus.de_out          <= s2_strb[4];
         bus.vsync_out       <= s2_strb[3];
         bus.hsync_out       <= s2_strb[2];
         bus.frame_start_out <= s2_strb[1];
         bus.line_start_out  <= s2_strb[0];
      end
   end
endmodule

// File: tb/tb_video_layer_mixer.sv
// Bench for video_layer_mixer: directed scenarios plus randomized traffic against a
// behavioural compositor model (visible-layer list, top-two blend, 3-deep output queue).
module tb_video_layer_mixer;
   localparam int N    = 4;
   localparam int C    = 10;
   localparam int A    = 4;
   localparam int AMAX = (1 << A) - 1;

   typedef struct {
      logic [C-1:0] r;
      logic [C-1:0] g;
      logic [C-1:0] b;
      logic [4:0]   strb;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass  = 0;
   int   n_total = 0;

   bit   m_pen[N];
   bit   m_aen[N];
   int   m_pkey[N][3];
   int   m_akey[N][3];
   int   m_palpha[N];
   int   m_aalpha[N];
   bit   m_pflag;
   exp_t q[$];
   exp_t ex;

   always #5 clk = ~clk;

   video_layer_mixer_if #(.NLAYERS(N), .COLSPC(C), .ALPHASPC(A)) bus ();

   video_layer_mixer #(.NLAYERS(N), .COLSPC(C), .ALPHASPC(A)) dut (
      .video_clk_pix (clk),
      .video_rst_n   (rst_n),
      .bus           (bus)
   );

   initial begin
      #200000;
      $display("FAIL watchdog expired: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [4:0] strb_out();
      return {bus.de_out, bus.vsync_out, bus.hsync_out, bus.frame_start_out, bus.line_start_out};
   endfunction

   function automatic exp_t model_pixel();
      exp_t e;
      int   vis[$];
      int   px[N][3];
      int   t[3];
      int   b[3];
      int   o[3];
      int   a;
      for (int i = 0; i < N; i++) begin
         px[i][0] = int'(bus.layer_red[i]);
         px[i][1] = int'(bus.layer_green[i]);
         px[i][2] = int'(bus.layer_blue[i]);
         if (m_aen[i] && (px[i][0] != m_akey[i][0] || px[i][1] != m_akey[i][1] ||
                          px[i][2] != m_akey[i][2]))
            vis.push_back(i);
      end
      a = AMAX;
      for (int c = 0; c < 3; c++) begin
         t[c] = 0;
         b[c] = 0;
      end
      if (vis.size() > 0) begin
         for (int c = 0; c < 3; c++) t[c] = px[vis[vis.size()-1]][c];
         a = m_aalpha[vis[vis.size()-1]];
      end
      if (vis.size() > 1)
         for (int c = 0; c < 3; c++) b[c] = px[vis[vis.size()-2]][c];
      for (int c = 0; c < 3; c++) begin
         o[c] = (a == AMAX) ? t[c] : (t[c] * a + b[c] * ((1 << A) - a)) / (1 << A);
         if (!bus.video_enable) o[c] = 0;
      end
      e.r    = C'(o[0]);
      e.g    = C'(o[1]);
      e.b    = C'(o[2]);
      e.strb = {bus.video_enable, bus.vsync, bus.hsync, bus.frame_start, bus.line_start};
      return e;
   endfunction

   task automatic model_cfg_update();
      int s;
      if (bus.frame_start) begin
         for (int i = 0; i < N; i++) begin
            m_aen[i]    = m_pen[i];
            m_aalpha[i] = m_palpha[i];
            for (int c = 0; c < 3; c++) m_akey[i][c] = m_pkey[i][c];
         end
         m_pflag = 1'b0;
      end
      if (bus.cfg_wr && int'(bus.cfg_sel) < N) begin
         s            = int'(bus.cfg_sel);
         m_pen[s]     = bus.cfg_en;
         m_pkey[s][0] = int'(bus.cfg_key[3*C-1 -: C]);
         m_pkey[s][1] = int'(bus.cfg_key[2*C-1 -: C]);
         m_pkey[s][2] = int'(bus.cfg_key[C-1:0]);
         m_palpha[s]  = int'(bus.cfg_alpha);
         m_pflag      = 1'b1;
      end
   endtask

   task automatic model_reset();
      exp_t z;
      for (int i = 0; i < N; i++) begin
         m_pen[i]    = 1'b1;
         m_aen[i]    = 1'b1;
         m_palpha[i] = AMAX;
         m_aalpha[i] = AMAX;
         for (int c = 0; c < 3; c++) begin
            m_pkey[i][c] = 0;
            m_akey[i][c] = 0;
         end
      end
      m_pflag = 1'b0;
      z.r = '0; z.g = '0; z.b = '0; z.strb = '0;
      q.delete();
      q.push_back(z);
      q.push_back(z);
      ex = z;
   endtask

   task automatic step();
      exp_t e;
      e = model_pixel();
      @(posedge clk);
      model_cfg_update();
      q.push_back(e);
      while (q.size() > 3) void'(q.pop_front());
      ex = q[0];
      #1;
   endtask

   task automatic clear_inputs();
      bus.video_enable = 1'b1;
      bus.vsync        = 1'b0;
      bus.hsync        = 1'b0;
      bus.frame_start  = 1'b0;
      bus.line_start   = 1'b0;
      bus.layer_red    = '0;
      bus.layer_green  = '0;
      bus.layer_blue   = '0;
      bus.cfg_wr       = 1'b0;
      bus.cfg_sel      = '0;
      bus.cfg_en       = 1'b0;
      bus.cfg_key      = '0;
      bus.cfg_alpha    = '0;
   endtask

   task automatic set_pix(input int i, input int r, input int g, input int b);
      bus.layer_red[i]   = C'(r);
      bus.layer_green[i] = C'(g);
      bus.layer_blue[i]  = C'(b);
   endtask

   task automatic write_cfg(input int sel, input bit en, input int kr, input int kg,
                            input int kb, input int alpha, input bit with_frame);
      bus.cfg_wr      = 1'b1;
      bus.cfg_sel     = 2'(sel);
      bus.cfg_en      = en;
      bus.cfg_key     = {C'(kr), C'(kg), C'(kb)};
      bus.cfg_alpha   = A'(alpha);
      bus.frame_start = with_frame;
      step();
      bus.cfg_wr      = 1'b0;
      bus.frame_start = 1'b0;
   endtask

   task automatic frame();
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      model_reset();
      rst_n = 1'b0;
      set_pix(2, 300, 400, 500);
      bus.vsync = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if ({bus.red, bus.green, bus.blue} !== 30'd0)
         $display("FAIL reset_rgb got %0d,%0d,%0d want 0,0,0", bus.red, bus.green, bus.blue);
      else n_pass++;
      n_total++;
      if (strb_out() !== 5'd0) $display("FAIL reset_strobes got %b want 00000", strb_out());
      else n_pass++;
      n_total++;
      if (bus.cfg_pending !== 1'b0) $display("FAIL reset_pending got %b want 0", bus.cfg_pending);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      clear_inputs();
      model_reset();
   endtask

   task automatic test_priority();
      clear_inputs();
      set_pix(0, 100, 0, 0);
      set_pix(2, 0, 200, 0);
      set_pix(3, 0, 0, 0);
      repeat (3) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue} !== {10'd0, 10'd200, 10'd0})
         $display("FAIL priority got %0d,%0d,%0d want 0,200,0", bus.red, bus.green, bus.blue);
      else n_pass++;
      n_total++;
      if ({bus.red, bus.green, bus.blue} !== {ex.r, ex.g, ex.b})
         $display("FAIL priority_model got %0d,%0d,%0d want %0d,%0d,%0d",
                  bus.red, bus.green, bus.blue, ex.r, ex.g, ex.b);
      else n_pass++;
   endtask

   task automatic test_alpha();
      clear_inputs();
      write_cfg(0, 1'b0, 0, 0, 0, AMAX, 1'b0);
      write_cfg(2, 1'b0, 0, 0, 0, AMAX, 1'b0);
      write_cfg(3, 1'b1, 0, 0, 0, 8, 1'b0);
      frame();
      set_pix(3, 1000, 0, 0);
      set_pix(1, 0, 1000, 0);
      repeat (3) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue} !== {10'd500, 10'd500, 10'd0})
         $display("FAIL alpha8 got %0d,%0d,%0d want 500,500,0", bus.red, bus.green, bus.blue);
      else n_pass++;
      write_cfg(3, 1'b1, 0, 0, 0, AMAX, 1'b0);
      frame();
      repeat (3) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue} !== {10'd1000, 10'd0, 10'd0})
         $display("FAIL alpha15 got %0d,%0d,%0d want 1000,0,0", bus.red, bus.green, bus.blue);
      else n_pass++;
   endtask

   task automatic test_key();
      clear_inputs();
      write_cfg(0, 1'b1, 0, 0, 0, AMAX, 1'b0);
      write_cfg(1, 1'b1, 0, 0, 0, AMAX, 1'b0);
      write_cfg(2, 1'b1, 0, 0, 0, AMAX, 1'b0);
      write_cfg(3, 1'b1, 5, 5, 5, AMAX, 1'b0);
      frame();
      set_pix(2, 7, 7, 7);
      set_pix(3, 5, 5, 6);
      repeat (3) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue} !== {10'd5, 10'd5, 10'd6})
         $display("FAIL key_blue_diff got %0d,%0d,%0d want 5,5,6", bus.red, bus.green, bus.blue);
      else n_pass++;
      set_pix(3, 6, 5, 5);
      repeat (3) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue} !== {10'd6, 10'd5, 10'd5})
         $display("FAIL key_red_diff got %0d,%0d,%0d want 6,5,5", bus.red, bus.green, bus.blue);
      else n_pass++;
      set_pix(2, 0, 0, 0);
      set_pix(3, 5, 5, 5);
      repeat (3) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue, bus.de_out} !== {30'd0, 1'b1})
         $display("FAIL key_all_hidden got %0d,%0d,%0d de=%b want 0,0,0 de=1",
                  bus.red, bus.green, bus.blue, bus.de_out);
      else n_pass++;
   endtask

   task automatic test_double_buffer();
      clear_inputs();
      set_pix(3, 300, 300, 300);
      set_pix(2, 0, 200, 0);
      write_cfg(3, 1'b0, 5, 5, 5, AMAX, 1'b0);
      n_total++;
      if (bus.cfg_pending !== 1'b1) $display("FAIL dbuf_pending_set got %b want 1", bus.cfg_pending);
      else n_pass++;
      repeat (3) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue, bus.cfg_pending} !== {10'd300, 10'd300, 10'd300, 1'b1})
         $display("FAIL dbuf_before_frame got %0d,%0d,%0d p=%b want 300,300,300 p=1",
                  bus.red, bus.green, bus.blue, bus.cfg_pending);
      else n_pass++;
      frame();
      n_total++;
      if (bus.cfg_pending !== 1'b0) $display("FAIL dbuf_pending_clear got %b want 0", bus.cfg_pending);
      else n_pass++;
      repeat (2) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue} !== {10'd300, 10'd300, 10'd300})
         $display("FAIL dbuf_frame_pixel got %0d,%0d,%0d want 300,300,300",
                  bus.red, bus.green, bus.blue);
      else n_pass++;
      step();
      n_total++;
      if ({bus.red, bus.green, bus.blue} !== {10'd0, 10'd200, 10'd0})
         $display("FAIL dbuf_after_frame got %0d,%0d,%0d want 0,200,0", bus.red, bus.green, bus.blue);
      else n_pass++;
      write_cfg(3, 1'b0, 5, 5, 5, AMAX, 1'b0);
      write_cfg(3, 1'b1, 5, 5, 5, AMAX, 1'b1);
      n_total++;
      if (bus.cfg_pending !== 1'b1)
         $display("FAIL dbuf_same_cycle_pending got %b want 1", bus.cfg_pending);
      else n_pass++;
      repeat (4) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue} !== {10'd0, 10'd200, 10'd0})
         $display("FAIL dbuf_same_cycle_not_applied got %0d,%0d,%0d want 0,200,0",
                  bus.red, bus.green, bus.blue);
      else n_pass++;
      frame();
      repeat (3) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue, bus.cfg_pending} !== {10'd300, 10'd300, 10'd300, 1'b0})
         $display("FAIL dbuf_same_cycle_applied got %0d,%0d,%0d p=%b want 300,300,300 p=0",
                  bus.red, bus.green, bus.blue, bus.cfg_pending);
      else n_pass++;
   endtask

   task automatic test_blanking_align();
      clear_inputs();
      set_pix(2, 0, 200, 0);
      set_pix(3, 300, 300, 300);
      bus.video_enable = 1'b0;
      repeat (3) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue, bus.de_out} !== 31'd0)
         $display("FAIL blank_rgb got %0d,%0d,%0d de=%b want 0,0,0 de=0",
                  bus.red, bus.green, bus.blue, bus.de_out);
      else n_pass++;
      for (int k = 0; k < 40; k++) begin
         bus.video_enable = 1'($urandom_range(0, 1));
         bus.vsync        = 1'($urandom_range(0, 1));
         bus.hsync        = 1'($urandom_range(0, 1));
         bus.frame_start  = 1'($urandom_range(0, 1));
         bus.line_start   = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++)
            set_pix(i, $urandom_range(1, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
         step();
         n_total++;
         if (strb_out() !== ex.strb)
            $display("FAIL align_strobes cycle %0d got %b want %b", k, strb_out(), ex.strb);
         else n_pass++;
         n_total++;
         if ({bus.red, bus.green, bus.blue} !== {ex.r, ex.g, ex.b})
            $display("FAIL align_rgb cycle %0d got %0d,%0d,%0d want %0d,%0d,%0d",
                     k, bus.red, bus.green, bus.blue, ex.r, ex.g, ex.b);
         else n_pass++;
      end
   endtask

   function automatic int rand_chan();
      case ($urandom_range(0, 3))
         0:       return 0;
         1:       return 5;
         default: return int'($urandom_range(0, 1023));
      endcase
   endfunction

   task automatic test_random();
      clear_inputs();
      for (int k = 0; k < 300; k++) begin
         bus.video_enable = ($urandom_range(0, 7) != 0);
         bus.frame_start  = ($urandom_range(0, 15) == 0);
         bus.line_start   = ($urandom_range(0, 7) == 0);
         bus.cfg_wr       = ($urandom_range(0, 5) == 0);
         bus.cfg_sel      = 2'($urandom_range(0, N - 1));
         bus.cfg_en       = ($urandom_range(0, 3) != 0);
         bus.cfg_key      = {C'($urandom_range(0, 1) * 5), C'($urandom_range(0, 1) * 5),
                             C'($urandom_range(0, 1) * 5)};
         bus.cfg_alpha    = A'($urandom_range(0, AMAX));
         for (int i = 0; i < N; i++) set_pix(i, rand_chan(), rand_chan(), rand_chan());
         step();
         n_total++;
         if ({bus.red, bus.green, bus.blue, bus.cfg_pending} !== {ex.r, ex.g, ex.b, m_pflag})
            $display("FAIL random cycle %0d got %0d,%0d,%0d p=%b want %0d,%0d,%0d p=%b",
                     k, bus.red, bus.green, bus.blue, bus.cfg_pending,
                     ex.r, ex.g, ex.b, m_pflag);
         else n_pass++;
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_frame();
      clear_inputs();
      write_cfg(3, 1'b1, 0, 0, 0, 3, 1'b1);
      write_cfg(2, 1'b0, 0, 0, 0, AMAX, 1'b0);
      set_pix(0, 100, 0, 0);
      set_pix(2, 0, 200, 0);
      set_pix(3, 900, 900, 900);
      repeat (4) step();
      rst_n = 1'b0;
      #2;
      n_total++;
      if ({bus.red, bus.green, bus.blue, strb_out(), bus.cfg_pending} !== 36'd0)
         $display("FAIL midreset_flush got %0d,%0d,%0d s=%b p=%b want 0,0,0 s=00000 p=0",
                  bus.red, bus.green, bus.blue, strb_out(), bus.cfg_pending);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      set_pix(3, 0, 0, 0);
      repeat (3) step();
      n_total++;
      if ({bus.red, bus.green, bus.blue, bus.cfg_pending} !== {10'd0, 10'd200, 10'd0, 1'b0})
         $display("FAIL midreset_defaults got %0d,%0d,%0d p=%b want 0,200,0 p=0",
                  bus.red, bus.green, bus.blue, bus.cfg_pending);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_priority();
      test_alpha();
      test_key();
      test_double_buffer();
      test_blanking_align();
      test_random();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
